// File: rtl/pwm_duty_ctrl.sv
// pwm_duty_ctrl: debounced pushbutton duty controller with auto-repeat.
// Steps land in duty_pend; duty follows only at PWM period boundaries.

module pwm_duty_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [31:0] HOLD_CYCLES     = 32'd25000000,
  parameter logic [31:0] REPEAT_CYCLES   = 32'd5000000,
  parameter logic [7:0]  DUTY_MAX        = 8'd100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       inc1,
  input  logic       dec,
  input  logic       dec1,
  input  logic       period_end,
  output logic [7:0] duty,
  output logic [7:0] duty_pend,
  output logic       pend
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DB_PRESS = 3'd1;
  localparam logic [2:0] S_HELD     = 3'd2;
  localparam logic [2:0] S_REPEAT   = 3'd3;
  localparam logic [2:0] S_DB_REL   = 3'd4;

  localparam logic [31:0] DB_LAST =
    {16'd0, DEBOUNCE_CYCLES} - 32'd1;
  localparam logic [31:0] HOLD_LAST = HOLD_CYCLES - 32'd1;
  localparam logic [31:0] REP_LAST  = REPEAT_CYCLES - 32'd1;

  // index order is arbitration priority: inc, dec, dec1, inc1
  logic [3:0]  btn_raw;
  logic [3:0]  btn;
  logic [3:0]  step;

  logic [1:0]  sync_q  [4];
  logic [1:0]  sync_d  [4];
  logic [2:0]  state_q [4];
  logic [2:0]  state_d [4];
  logic [31:0] cnt_q   [4];
  logic [31:0] cnt_d   [4];

  logic [7:0]  duty_q, duty_d;
  logic [7:0]  duty_pend_q, duty_pend_d;
  logic        pend_q, pend_d;

  logic [8:0]  pend_w, max_w, up1_w, up10_w;
  logic [7:0]  up1, up10, dn1, dn10;

  assign btn_raw = {inc1, dec1, dec, inc};

  // two-flop synchronisers feeding the per-button state machines
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      sync_d[i] = {sync_q[i][0], btn_raw[i]};
      btn[i]    = sync_q[i][1];
    end
  end

  // per-button debounce / hold / repeat machine, step is a 1-cycle pulse
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i] + 32'd1;
      step[i]    = 1'b0;
      unique case (state_q[i])
        S_IDLE: begin
          cnt_d[i] = '0;
          if (!btn[i]) state_d[i] = S_DB_PRESS;
        end
        S_DB_PRESS: begin
          if (btn[i]) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DB_LAST) begin
            state_d[i] = S_HELD;
            cnt_d[i]   = '0;
            step[i]    = 1'b1;
          end
        end
        S_HELD: begin
          if (btn[i]) begin
            state_d[i] = S_DB_REL;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == HOLD_LAST) begin
            state_d[i] = S_REPEAT;
            cnt_d[i]   = '0;
            step[i]    = 1'b1;
          end
        end
        S_REPEAT: begin
          if (btn[i]) begin
            state_d[i] = S_DB_REL;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == REP_LAST) begin
            cnt_d[i]   = '0;
            step[i]    = 1'b1;
          end
        end
        S_DB_REL: begin
          if (!btn[i]) begin
            state_d[i] = S_HELD;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == DB_LAST) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end
        end
        default: begin
          state_d[i] = S_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // saturating step candidates, widened so +10 near 255 cannot wrap
  always_comb begin
    pend_w = {1'b0, duty_pend_q};
    max_w  = {1'b0, DUTY_MAX};
    up1_w  = pend_w + 9'd1;
    up10_w = pend_w + 9'd10;
    up1    = (up1_w > max_w) ? DUTY_MAX : up1_w[7:0];
    up10   = (up10_w > max_w) ? DUTY_MAX : up10_w[7:0];
    dn1    = (pend_w < 9'd1) ? 8'd0 : duty_pend_q - 8'd1;
    dn10   = (pend_w < 9'd10) ? 8'd0 : duty_pend_q - 8'd10;
  end

  // one step per cycle; duty picks up the old pending value at wrap
  always_comb begin
    duty_pend_d = duty_pend_q;
    priority case (1'b1)
      step[0]: duty_pend_d = up1;
      step[1]: duty_pend_d = dn1;
      step[2]: duty_pend_d = dn10;
      step[3]: duty_pend_d = up10;
      default: duty_pend_d = duty_pend_q;
    endcase
    duty_d = period_end ? duty_pend_q : duty_q;
    pend_d = (duty_d != duty_pend_d);
  end

  // button state; synchronisers idle released (high) out of reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        sync_q[i]  <= 2'b11;
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        sync_q[i]  <= sync_d[i];
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // duty registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      duty_q      <= '0;
      duty_pend_q <= '0;
      pend_q      <= 1'b0;
    end else begin
      duty_q      <= duty_d;
      duty_pend_q <= duty_pend_d;
      pend_q      <= pend_d;
    end
  end

  assign duty      = duty_q;
  assign duty_pend = duty_pend_q;
  assign pend      = pend_q;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// tb_pwm_duty_ctrl: directed and random button traffic vs a
// run-length based reference model of the duty controller.

module tb_pwm_duty_ctrl;

  localparam int DB   = 4;
  localparam int HOLD = 20;
  localparam int REP  = 8;
  localparam int DMAX = 100;

  logic       clk;
  logic       reset;
  logic       inc, inc1, dec, dec1;
  logic       period_end;
  logic [7:0] duty, duty_pend;
  logic       pend;

  pwm_duty_ctrl #(
    .DEBOUNCE_CYCLES(16'd4),
    .HOLD_CYCLES(32'd20),
    .REPEAT_CYCLES(32'd8),
    .DUTY_MAX(8'd100)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .inc(inc),
    .inc1(inc1),
    .dec(dec),
    .dec1(dec1),
    .period_end(period_end),
    .duty(duty),
    .duty_pend(duty_pend),
    .pend(pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // raw button levels (0 = pressed), priority order inc, dec, dec1, inc1
  bit raw [4];
  bit rst_v;
  bit pe_rand;
  int pe_cnt;

  // reference model
  int m_duty;
  int m_pend;
  bit m_pflag;
  bit m_s1 [4];
  bit m_s2 [4];
  bit m_acc [4];
  bit m_step [4];
  int m_low [4];
  int m_high [4];
  int m_base [4];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d",
               tag, $time, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_duty  = 0;
    m_pend  = 0;
    m_pflag = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_s1[i]   = 1'b1;
      m_s2[i]   = 1'b1;
      m_acc[i]  = 1'b0;
      m_step[i] = 1'b0;
      m_low[i]  = 0;
      m_high[i] = 0;
      m_base[i] = 0;
    end
  endfunction

  // A press is accepted once the synced level has been low DB+1 cycles.
  // While accepted, steps fall at low-run lengths base+HOLD+k*REP,
  // where base restarts at 1 after any high glitch. DB+1 highs release.
  function automatic void model_edge();
    int nd;
    int np;
    bit s;
    if (!reset) begin
      model_reset();
      return;
    end
    nd = period_end ? m_pend : m_duty;
    np = m_pend;
    if (m_step[0])
      np = (m_pend + 1 > DMAX) ? DMAX : m_pend + 1;
    else if (m_step[1])
      np = (m_pend < 1) ? 0 : m_pend - 1;
    else if (m_step[2])
      np = (m_pend < 10) ? 0 : m_pend - 10;
    else if (m_step[3])
      np = (m_pend + 10 > DMAX) ? DMAX : m_pend + 10;
    m_duty  = nd;
    m_pend  = np;
    m_pflag = (nd != np);
    for (int i = 0; i < 4; i++) begin
      m_s2[i] = m_s1[i];
      m_s1[i] = raw[i];
      s = m_s2[i];
      m_step[i] = 1'b0;
      if (!s) begin
        m_low[i]++;
        m_high[i] = 0;
      end else begin
        m_high[i]++;
        m_low[i] = 0;
      end
      if (!m_acc[i]) begin
        if (!s && m_low[i] == DB + 1) begin
          m_step[i] = 1'b1;
          m_acc[i]  = 1'b1;
          m_base[i] = DB + 1;
        end
      end else if (s) begin
        m_base[i] = 1;
        if (m_high[i] == DB + 1) m_acc[i] = 1'b0;
      end else if (m_low[i] >= m_base[i] + HOLD &&
                   (m_low[i] - m_base[i] - HOLD) % REP == 0) begin
        m_step[i] = 1'b1;
      end
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    reset = rst_v;
    inc   = raw[0];
    dec   = raw[1];
    dec1  = raw[2];
    inc1  = raw[3];
    pe_cnt = (pe_cnt == 49) ? 0 : pe_cnt + 1;
    period_end = pe_rand ? ($urandom_range(0, 4) == 0)
                         : (pe_cnt == 49);
    @(posedge clk);
    model_edge();
    #1;
    check("duty", 32'(duty), m_duty);
    check("duty_pend", 32'(duty_pend), m_pend);
    check("pend", 32'(pend), 32'(m_pflag));
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic press(input int b, input int hold, input int rel);
    raw[b] = 1'b0;
    ticks(hold);
    raw[b] = 1'b1;
    ticks(rel);
  endtask

  task automatic set_value(input int v);
    rst_v = 1'b0;
    ticks(3);
    rst_v = 1'b1;
    ticks(2);
    for (int k = 0; k < v / 10; k++) press(3, 8, 10);
    for (int k = 0; k < v % 10; k++) press(0, 8, 10);
    check("set_value", 32'(duty_pend), v);
  endtask

  initial begin
    reset = 1'b1;
    inc = 1'b1; inc1 = 1'b1; dec = 1'b1; dec1 = 1'b1;
    period_end = 1'b0;
    rst_v = 1'b0;
    pe_rand = 1'b0;
    for (int i = 0; i < 4; i++) raw[i] = 1'b1;
    model_reset();
    #2 reset = 1'b0;

    // idle after reset
    ticks(5);
    check("rst_duty", 32'(duty), 0);
    check("rst_duty_pend", 32'(duty_pend), 0);
    check("rst_pend", 32'(pend), 0);
    rst_v = 1'b1;
    ticks(200);
    check("idle_duty_pend", 32'(duty_pend), 0);

    // clean inc press: first step 7 edges after the raw edge
    raw[0] = 1'b0;
    ticks(6);
    check("inc_before_step", 32'(duty_pend), 0);
    tick();
    check("inc_first_step", 32'(duty_pend), 1);
    check("inc_pend_flag", 32'(pend), 1);
    ticks(3);
    raw[0] = 1'b1;
    ticks(60);
    check("inc_committed", 32'(duty), 1);
    check("inc_pend_clear", 32'(pend), 0);
    check("inc_single_step", 32'(duty_pend), 1);

    // bouncing dec1 from 25
    set_value(25);
    for (int k = 0; k < 12; k++) begin
      raw[2] = k[1];
      tick();
    end
    check("bounce_no_step", 32'(duty_pend), 25);
    raw[2] = 1'b0;
    ticks(10);
    check("bounce_settled", 32'(duty_pend), 15);
    for (int k = 0; k < 12; k++) begin
      raw[2] = !k[1];
      tick();
    end
    raw[2] = 1'b1;
    ticks(12);
    check("bounce_release", 32'(duty_pend), 15);

    // saturation at both ends
    set_value(95);
    press(3, 8, 10);
    check("sat_up_1", 32'(duty_pend), 100);
    press(3, 8, 10);
    check("sat_up_2", 32'(duty_pend), 100);
    set_value(5);
    press(2, 8, 10);
    check("sat_dn10", 32'(duty_pend), 0);
    press(1, 8, 10);
    check("sat_dn1", 32'(duty_pend), 0);

    // long hold with auto-repeat
    set_value(0);
    raw[0] = 1'b0;
    ticks(60);
    raw[0] = 1'b1;
    ticks(70);

    // simultaneous inc and dec1, then reset mid-hold
    set_value(50);
    raw[0] = 1'b0;
    raw[2] = 1'b0;
    ticks(7);
    check("simul_inc_wins", 32'(duty_pend), 51);
    ticks(5);
    @(negedge clk);
    reset = 1'b0;
    rst_v = 1'b0;
    #1;
    model_reset();
    check("async_rst_duty", 32'(duty), 0);
    check("async_rst_pend_val", 32'(duty_pend), 0);
    check("async_rst_pend", 32'(pend), 0);
    ticks(4);
    rst_v = 1'b1;
    ticks(6);
    check("post_rst_debounce", 32'(duty_pend), 0);
    tick();
    check("post_rst_step", 32'(duty_pend), 1);
    raw[0] = 1'b1;
    raw[2] = 1'b1;
    ticks(12);

    // random traffic with irregular and back-to-back period_end
    pe_rand = 1'b1;
    for (int seg = 0; seg < 150; seg++) begin
      rst_v = ($urandom_range(0, 59) != 0);
      for (int i = 0; i < 4; i++)
        raw[i] = ($urandom_range(0, 2) != 0);
      ticks($urandom_range(1, 40));
    end
    rst_v = 1'b1;
    for (int i = 0; i < 4; i++) raw[i] = 1'b1;
    ticks(20);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
